// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;
  localparam int ENTRY_W = PC_W + INSTR_W;

  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
  localparam logic [PC_W-1:0] PC_STEP  = 16'h0002;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // One fetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Word address presented to the instruction memory for a byte PC.
  function automatic logic [PC_W-2:0] pc_word(input logic [PC_W-1:0] pc);
    return pc[PC_W-1:1];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, instr} pairs between memory return and decode.
// Pointers carry one extra bit so full and empty are distinguishable; flush
// empties the queue in one cycle and takes priority over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [ENTRY_W-1:0]       head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;
  logic               full_s;
  logic               do_push_s;
  logic               do_pop_s;

  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign full_s = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign count  = wr_ptr_r - rd_ptr_r;
  assign head   = mem_r[rd_ptr_r[AW-1:0]];

  // Qualify requests so a stray push on full or pop on empty cannot corrupt the pointers.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_push_s = push && !full_s;
      do_pop_s  = pop && !empty;
    end
  end

  // Read/write pointer update; flush returns both to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage; cleared on reset so the head never shows stale data after power-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one read per cycle into a
// fixed-latency memory port, tracks in-flight reads and buffers returns for
// decode behind a valid/ready handshake. Redirect and halt kill wrong-path work.
// Optional feature macro: FETCH_BYPASS_EN (present a return straight to decode
// when the queue is empty, saving one cycle of latency).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int Q_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [14:0] imem_raddr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc
);

  localparam int CNT_W = $clog2(Q_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W+1)'(Q_DEPTH);

  // Parameter sanity: a full queue plus every in-flight return must fit.
  generate
    if (Q_DEPTH < MEM_LAT + 1) begin : g_bad_depth
      $error("fetch_unit: Q_DEPTH must be at least MEM_LAT+1");
    end
    if ((Q_DEPTH & (Q_DEPTH - 1)) != 0) begin : g_bad_pow2
      $error("fetch_unit: Q_DEPTH must be a power of 2");
    end
    if (MEM_LAT < 1) begin : g_bad_lat
      $error("fetch_unit: MEM_LAT must be at least 1");
    end
  endgenerate

  fetch_state_e       state_r;
  fetch_state_e       state_next_s;
  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    pc_next_s;
  logic [PC_W-1:0]    issue_pc_s;
  logic [MEM_LAT-1:0] infl_valid_r;
  logic [PC_W-1:0]    infl_pc_r [MEM_LAT];
  logic [CNT_W-1:0]   infl_cnt_s;
  logic [CNT_W-1:0]   q_count_s;
  logic [CNT_W:0]     credit_used_s;
  logic               run_s;
  logic               kill_s;
  logic               issue_s;
  logic               ret_s;
  logic               byp_s;
  logic               push_s;
  logic               pop_s;
  logic               q_empty_s;
  logic [ENTRY_W-1:0] q_head_s;
  logic [ENTRY_W-1:0] ret_entry_s;
  fetch_entry_t       head_s;
  logic               redirect_pc_unused_s;

  // Bit 0 of the jump target is meaningless for 16-bit aligned instructions.
  assign redirect_pc_unused_s = redirect_pc[0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: halt is sticky, only reset brings fetch back.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (halt) begin
          state_next_s = HALTED;
        end else begin
          state_next_s = RUN;
        end
      end
      HALTED:  state_next_s = HALTED;
      default: state_next_s = RUN;
    endcase
  end

  // Count valid in-flight reads for the credit check.
  always_comb begin
    infl_cnt_s = {CNT_W{1'b0}};
    for (int i = 0; i < MEM_LAT; i++) begin
      infl_cnt_s = infl_cnt_s + CNT_W'(infl_valid_r[i]);
    end
  end

  // Issue decision: redirect forces a read of the target; otherwise issue only
  // while in-flight plus buffered entries leave a guaranteed queue slot.
  always_comb begin
    run_s         = (state_r == RUN);
    kill_s        = redirect || halt || !run_s;
    credit_used_s = {1'b0, infl_cnt_s} + {1'b0, q_count_s};
    issue_pc_s    = pc_r;
    issue_s       = 1'b0;
    pc_next_s     = pc_r;
    if (redirect) begin
      issue_pc_s = {redirect_pc[PC_W-1:1], 1'b0};
    end else begin
      issue_pc_s = pc_r;
    end
    if (run_s && !halt) begin
      issue_s = redirect || (credit_used_s < CREDIT_LIM);
    end else begin
      issue_s = 1'b0;
    end
    if (issue_s) begin
      pc_next_s = issue_pc_s + PC_STEP;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Memory read address; held at zero while reset is asserted.
  always_comb begin
    imem_raddr = 15'd0;
    if (rst) begin
      imem_raddr = 15'd0;
    end else begin
      imem_raddr = pc_word(issue_pc_s);
    end
  end

  // Program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // In-flight shift register; kill drops every older read but keeps the new issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_valid_r <= {MEM_LAT{1'b0}};
      for (int i = 0; i < MEM_LAT; i++) begin
        infl_pc_r[i] <= RESET_PC;
      end
    end else begin
      infl_valid_r[0] <= issue_s;
      infl_pc_r[0]    <= issue_pc_s;
      for (int i = 1; i < MEM_LAT; i++) begin
        infl_valid_r[i] <= infl_valid_r[i-1] && !kill_s;
        infl_pc_r[i]    <= infl_pc_r[i-1];
      end
    end
  end

  // Return path and decode handshake; a redirect-cycle return is never used.
  always_comb begin
    ret_s       = infl_valid_r[MEM_LAT-1] && !redirect && run_s;
    ret_entry_s = {infl_pc_r[MEM_LAT-1], imem_rdata};
`ifdef FETCH_BYPASS_EN
    byp_s       = ret_s && q_empty_s;
`else
    byp_s       = 1'b0;
`endif
    head_s      = fetch_entry_t'(q_head_s);
    if (byp_s) begin
      head_s = fetch_entry_t'(ret_entry_s);
    end else begin
      head_s = fetch_entry_t'(q_head_s);
    end
    out_valid = run_s && (!q_empty_s || byp_s);
    pop_s     = out_valid && out_ready && !q_empty_s;
    push_s    = ret_s && !(byp_s && out_ready);
    out_instr = 16'h0000;
    out_pc    = 16'h0000;
    if (out_valid) begin
      out_instr = head_s.instr;
      out_pc    = head_s.pc;
    end else begin
      out_instr = 16'h0000;
      out_pc    = 16'h0000;
    end
  end

  fetch_queue #(
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (ret_entry_s),
    .pop       (pop_s),
    .flush     (kill_s),
    .head      (q_head_s),
    .empty     (q_empty_s),
    .count     (q_count_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: startup latency, stall/credit limit,
// redirect with a full queue, PC wrap, halt+redirect and reset restart.
module tb_fetch_unit;

  localparam int MEM_LAT = 2;
  localparam int Q_DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int          LAT         = 2;
  localparam logic [14:0] STALL_RADDR = 15'd10;
`else
  localparam int          LAT         = 3;
  localparam logic [14:0] STALL_RADDR = 15'd9;
`endif

  logic        clk;
  logic        rst;
  logic [14:0] imem_raddr;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  logic [14:0] a0_r;
  logic [14:0] a1_r;
  int          checks;
  int          errors;
  logic [15:0] exp_pc;
  logic [15:0] halt_pc;

  fetch_unit #(
    .MEM_LAT (MEM_LAT),
    .Q_DEPTH (Q_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_raddr  (imem_raddr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle memory: word n holds 0x1000 + n.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_r <= 15'd0;
      a1_r <= 15'd0;
    end else begin
      a0_r <= imem_raddr;
      a1_r <= a0_r;
    end
  end
  assign imem_rdata = 16'h1000 + {1'b0, a1_r};

  function automatic logic [15:0] exp_word(input logic [15:0] pc);
    return 16'h1000 + {1'b0, pc[15:1]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycles right after reset release: nothing valid before LAT, then 0,2,4,...
  task automatic startup_check(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c < LAT) begin
        check_eq("startup_valid", 32'(out_valid), 32'd0);
        check_eq("startup_raddr", 32'(imem_raddr), 32'(c));
      end else begin
        check_eq("startup_valid", 32'(out_valid), 32'd1);
        check_eq("startup_pc", 32'(out_pc), 32'(exp_pc));
        check_eq("startup_instr", 32'(out_instr), 32'(exp_word(exp_pc)));
        exp_pc = exp_pc + 16'd2;
      end
      @(posedge clk); #1;
    end
  endtask

  // One accepted instruction per cycle, in order.
  task automatic stream_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq("stream_valid", 32'(out_valid), 32'd1);
      check_eq("stream_pc", 32'(out_pc), 32'(exp_pc));
      check_eq("stream_instr", 32'(out_instr), 32'(exp_word(exp_pc)));
      exp_pc = exp_pc + 16'd2;
      @(posedge clk); #1;
    end
  endtask

  // Cycles after a redirect before the target can appear.
  task automatic redirect_gap;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      check_eq("redir_gap_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    exp_pc      = 16'h0000;
    halt_pc     = 16'h0000;
    rst         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h1234;
    halt        = 1'b0;
    out_ready   = 1'b1;

    // Reset state, with a redirect request that must not reach the address port.
    #12;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_instr", 32'(out_instr), 32'd0);
    check_eq("rst_pc", 32'(out_pc), 32'd0);
    check_eq("rst_raddr", 32'(imem_raddr), 32'd0);
    redirect = 1'b0;

    // Release reset; cycle 0 starts here.
    @(posedge clk); #1;
    rst = 1'b0;
    startup_check(8);

    // Decode stall for 10 cycles: head stable, issue frozen at the credit limit.
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_pc", 32'(out_pc), 32'(exp_pc));
      if (k >= 3) begin
        check_eq("stall_raddr", 32'(imem_raddr), 32'(STALL_RADDR));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    stream_cycles(12);

    // Fill the queue, then redirect to an odd target (bit 0 ignored).
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("fill_pc", 32'(out_pc), 32'(exp_pc));
      @(posedge clk); #1;
    end
    redirect    = 1'b1;
    redirect_pc = 16'h0041;
    out_ready   = 1'b1;
    @(negedge clk);
    check_eq("redir_raddr", 32'(imem_raddr), 32'h20);
    @(posedge clk); #1;
    redirect = 1'b0;
    redirect_gap();
    exp_pc = 16'h0040;
    stream_cycles(4);

    // PC wrap from the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 16'hFFFC;
    @(negedge clk);
    check_eq("wrap_raddr", 32'(imem_raddr), 32'h7FFE);
    @(posedge clk); #1;
    redirect = 1'b0;
    redirect_gap();
    exp_pc = 16'hFFFC;
    stream_cycles(6);

    // Halt coincident with redirect: halt wins, PC frozen, output dead until reset.
    halt_pc     = exp_pc + 16'(2 * LAT);
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    check_eq("halt_cycle_pc", 32'(out_pc), 32'(exp_pc));
    @(posedge clk); #1;
    halt     = 1'b0;
    redirect = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("halted_valid", 32'(out_valid), 32'd0);
      check_eq("halted_raddr", 32'(imem_raddr), 32'(halt_pc[15:1]));
      @(posedge clk); #1;
    end

    // Reset pulse restarts fetch at address 0.
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst2_valid", 32'(out_valid), 32'd0);
    check_eq("rst2_pc", 32'(out_pc), 32'd0);
    check_eq("rst2_raddr", 32'(imem_raddr), 32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    exp_pc = 16'h0000;
    startup_check(7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
